// File: rtl/mole_ctrl.sv
// Whack-a-mole game controller: turns the random stream into timed mole
// appearances, judges hits against the active hole and keeps score/miss counts.
module mole_ctrl #(
  parameter int NUM_HOLES   = 16,
  parameter int UP_TICKS    = 8,
  parameter int GAP_TICKS   = 2,
  parameter int GAME_ROUNDS = 30,
  parameter int SCORE_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rand_num,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   miss,
  output logic                 hit_ok,
  output logic                 busy,
  output logic                 game_over
);

  localparam int MAX_T = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW = $clog2(MAX_T + 1);
  localparam int RW = $clog2(GAME_ROUNDS + 1);
  localparam logic [4:0] IDX_MASK = 5'(NUM_HOLES - 1);

  typedef enum logic [2:0] {IDLE, GAP, SPAWN, UP, DONE} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [RW-1:0]        round, round_n;
  logic [4:0]           prev_idx, prev_idx_n;
  logic [4:0]           idx_raw, idx_sel;
  logic [NUM_HOLES-1:0] mole_n;
  logic [SCORE_W-1:0]   score_n, miss_n;
  logic                 hit_ok_n;
  logic                 end_round;

  // Hole decode; the mask works for every power-of-two hole count up to 32.
  assign idx_raw = (rand_num - 5'd1) & IDX_MASK;
  assign idx_sel = (idx_raw == prev_idx) ? ((idx_raw + 5'd1) & IDX_MASK) : idx_raw;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    round_n    = round;
    prev_idx_n = prev_idx;
    mole_n     = mole;
    score_n    = score;
    miss_n     = miss;
    hit_ok_n   = 1'b0;
    end_round  = 1'b0;

    case (state)
      IDLE, DONE: begin
        mole_n = '0;
        if (start) begin
          score_n = '0;
          miss_n  = '0;
          round_n = '0;
          timer_n = TW'(GAP_TICKS);
          state_n = GAP;
        end
      end
      GAP: begin
        mole_n = '0;
        if (tick) begin
          timer_n = timer - TW'(1);
          if (timer <= TW'(1)) state_n = SPAWN;
        end
      end
      SPAWN: begin
        if (rand_num != 5'd0 && rand_num != 5'd31) begin
          prev_idx_n = idx_sel;
          mole_n     = NUM_HOLES'(1) << idx_sel;
          timer_n    = TW'(UP_TICKS);
          state_n    = UP;
        end
      end
      UP: begin
        // The one-hot mole register doubles as the mask of the active hole.
        if ((hit & mole) != '0) begin
          if (score != '1) score_n = score + SCORE_W'(1);
          hit_ok_n  = 1'b1;
          end_round = 1'b1;
        end else if (tick) begin
          if (timer <= TW'(1)) begin
            if (miss != '1) miss_n = miss + SCORE_W'(1);
            end_round = 1'b1;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
        if (end_round) begin
          mole_n  = '0;
          round_n = round + RW'(1);
          if (round_n == RW'(GAME_ROUNDS)) begin
            state_n = DONE;
          end else begin
            timer_n = TW'(GAP_TICKS);
            state_n = GAP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // busy and game_over follow the next state so they line up with the other registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      round     <= '0;
      prev_idx  <= 5'(NUM_HOLES - 1);
      mole      <= '0;
      score     <= '0;
      miss      <= '0;
      hit_ok    <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      round     <= round_n;
      prev_idx  <= prev_idx_n;
      mole      <= mole_n;
      score     <= score_n;
      miss      <= miss_n;
      hit_ok    <= hit_ok_n;
      busy      <= (state_n == GAP) || (state_n == SPAWN) || (state_n == UP);
      game_over <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_mole_ctrl.sv
// Scoreboard bench for mole_ctrl: expected moles and round results are queued
// as stimulus is driven and checked when the DUT shows a mole or ends a round.
module tb_mole_ctrl;

  localparam int NH = 16;
  localparam int SW = 2;
  localparam logic [SW-1:0] SMAX = '1;

  typedef struct {
    logic [SW-1:0] score;
    logic [SW-1:0] miss;
    logic          hit_ok;
  } end_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rand_num = 5'd0;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic [NH-1:0] hit = '0;
  logic [NH-1:0] mole;
  logic [SW-1:0] score, miss;
  logic          hit_ok, busy, game_over;

  int tests_run = 0;
  int tests_failed = 0;

  logic [NH-1:0] mole_q[$];
  end_t          end_q[$];
  int            m_prev = NH - 1;
  logic [SW-1:0] m_score = '0;
  logic [SW-1:0] m_miss = '0;
  int            idx;

  mole_ctrl #(
    .NUM_HOLES(NH), .UP_TICKS(4), .GAP_TICKS(2), .GAME_ROUNDS(4), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rand_num(rand_num), .tick(tick), .start(start),
    .hit(hit), .mole(mole), .score(score), .miss(miss), .hit_ok(hit_ok),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic tk, input logic [NH-1:0] ht);
    start = st;
    tick  = tk;
    hit   = ht;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick  = 1'b0;
    hit   = '0;
  endtask

  function automatic logic [NH-1:0] hole(input int i);
    return NH'(1) << i;
  endfunction

  task automatic expect_end(input logic was_hit);
    if (was_hit && m_score != SMAX) m_score = m_score + 1'b1;
    if (!was_hit && m_miss != SMAX) m_miss = m_miss + 1'b1;
    end_q.push_back('{m_score, m_miss, was_hit});
  endtask

  // Runs the gap and spawn from GAP; optionally parks in SPAWN on invalid values first.
  task automatic spawn_round(input logic [4:0] r, input logic hold_invalid, output int i);
    i = (int'(r) - 1) % NH;
    if (i == m_prev) i = (i + 1) % NH;
    m_prev = i;
    rand_num = hold_invalid ? 5'd0 : r;
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("gap_1", 32'(mole), 32'd0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("gap_2", 32'(mole), 32'd0);
    if (hold_invalid) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("rand0_no_mole", 32'({busy, mole}), 32'({1'b1, NH'(0)}));
      end
      rand_num = 5'd31;
      for (int k = 0; k < 2; k++) begin
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("rand31_no_mole", 32'({busy, mole}), 32'({1'b1, NH'(0)}));
      end
      rand_num = r;
    end
    mole_q.push_back(hole(i));
    applyStimulus(1'b0, 1'b0, '0);
    rand_num = 5'd0;
  endtask

  // Output monitor: pops expectations on mole appearance and on round end.
  logic [NH-1:0] prev_mole = '0;
  logic          prev_hit_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mole   = '0;
      prev_hit_ok = 1'b0;
    end else begin
      if (prev_hit_ok) checkOutput("hit_ok_len", 32'(hit_ok), 32'd0);
      if (prev_mole == '0 && mole != '0) begin
        if (mole_q.size() == 0) checkOutput("mole_unexpected", 32'(mole), 32'd0);
        else checkOutput("mole", 32'(mole), 32'(mole_q.pop_front()));
      end else if (prev_mole != '0 && mole == '0) begin
        if (end_q.size() == 0) begin
          checkOutput("round_end_unexpected", 32'(end_q.size()), 32'd1);
        end else begin
          end_t e;
          e = end_q.pop_front();
          checkOutput("end_score", 32'(score), 32'(e.score));
          checkOutput("end_miss", 32'(miss), 32'(e.miss));
          checkOutput("end_hit_ok", 32'(hit_ok), 32'(e.hit_ok));
        end
      end
      prev_mole   = mole;
      prev_hit_ok = hit_ok;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rst_mole", 32'(mole), 32'd0);
    checkOutput("rst_counts", 32'({score, miss}), 32'd0);
    checkOutput("rst_flags", 32'({hit_ok, busy, game_over}), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Game 1: decode, invalid values, repeat avoidance, hit vs timeout, game end
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("start_busy", 32'({busy, game_over}), 32'b10);
    checkOutput("start_counts", 32'({score, miss}), 32'd0);
    spawn_round(5'd5, 1'b1, idx);
    applyStimulus(1'b0, 1'b1, '0);
    expect_end(1'b1);
    applyStimulus(1'b0, 1'b1, hole(idx));
    applyStimulus(1'b0, 1'b0, '0);

    spawn_round(5'd21, 1'b0, idx);
    applyStimulus(1'b0, 1'b0, hole(4));
    repeat (3) applyStimulus(1'b0, 1'b1, '0);
    expect_end(1'b0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '1);

    spawn_round(5'd3, 1'b0, idx);
    repeat (3) applyStimulus(1'b0, 1'b1, '0);
    expect_end(1'b1);
    applyStimulus(1'b0, 1'b1, hole(idx));

    spawn_round(5'd3, 1'b0, idx);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("start_ignored", 32'({busy, score, miss}), 32'({1'b1, 2'd2, 2'd1}));
    repeat (3) applyStimulus(1'b0, 1'b1, '0);
    expect_end(1'b0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("done_flags", 32'({game_over, busy, mole}), 32'({2'b10, NH'(0)}));
    checkOutput("done_counts", 32'({score, miss}), 32'({2'd2, 2'd2}));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("done_hold", 32'({game_over, score, miss}), 32'({1'b1, 2'd2, 2'd2}));

    // Game 2: restart from DONE and saturate the score counter
    applyStimulus(1'b1, 1'b0, '0);
    m_score = '0;
    m_miss  = '0;
    checkOutput("restart", 32'({busy, game_over, score, miss}), 32'({2'b10, 4'd0}));
    for (int k = 0; k < 4; k++) begin
      spawn_round(5'($urandom_range(1, 30)), 1'b0, idx);
      expect_end(1'b1);
      applyStimulus(1'b0, 1'b0, hole(idx));
    end
    checkOutput("sat_score", 32'({game_over, score}), 32'({1'b1, SMAX}));

    // Game 3: asynchronous reset while a mole is up
    applyStimulus(1'b1, 1'b0, '0);
    m_score = '0;
    m_miss  = '0;
    spawn_round(5'd9, 1'b0, idx);
    applyStimulus(1'b0, 1'b1, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_mole", 32'(mole), 32'd0);
    checkOutput("async_rst_flags", 32'({hit_ok, busy, game_over}), 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    rst_n  = 1'b1;
    m_prev = NH - 1;
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("post_rst_idle", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    spawn_round(5'd16, 1'b0, idx);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("queues_drained", 32'(mole_q.size() + end_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
